// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, decode handshake, redirect input and status.
interface inst_fetch_ctrl_if;
    logic [7:0]  instAddr;
    logic [31:0] instruction;
    logic        fetchValid;
    logic        fetchReady;
    logic [31:0] fetchInst;
    logic [7:0]  fetchPc;
    logic        redirectValid;
    logic [7:0]  redirectTarget;
    logic        alignErr;
    logic        halted;

    modport master (
        output instAddr, fetchValid, fetchInst, fetchPc, alignErr, halted,
        input  instruction, fetchReady, redirectValid, redirectTarget
    );

    modport slave (
        input  instAddr, fetchValid, fetchInst, fetchPc, alignErr, halted,
        output instruction, fetchReady, redirectValid, redirectTarget
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, registers memory words into a one-entry
// valid/ready stage, and handles redirects, halt word and end-of-program.
module inst_fetch_ctrl #(
    parameter logic [7:0]  RESET_PC  = 8'd0,
    parameter logic [7:0]  PC_LIMIT  = 8'd124,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic             clk,
    input logic             rst_n,
    inst_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state, stateNext;
    logic [7:0]  pc, pcNext;
    logic        fetchValid;
    logic [31:0] fetchInst;
    logic [7:0]  fetchPc;
    logic        alignErr;
    logic        halted;

    logic        load;
    logic        redirAcc;
    logic        stopFetch;
    logic [7:0]  alignedTgt;

    always_comb begin
        redirAcc   = bus.redirectValid && (state != IDLE);
        alignedTgt = bus.redirectTarget & 8'hFC;
        load       = (state == RUN) && !bus.redirectValid && (!fetchValid || bus.fetchReady);
        stopFetch  = (pc == PC_LIMIT) || (bus.instruction == HALT_WORD);
    end

    // Redirect outranks everything; a load of the last/halt word parks the PC.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        if (state == IDLE) begin
            stateNext = RUN;
        end else if (redirAcc) begin
            pcNext    = alignedTgt;
            stateNext = (alignedTgt <= PC_LIMIT) ? RUN : HALT;
        end else if (load) begin
            if (stopFetch) stateNext = HALT;
            else           pcNext    = pc + 8'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchValid <= 1'b0;
            fetchInst  <= '0;
            fetchPc    <= '0;
            alignErr   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            alignErr <= redirAcc && (bus.redirectTarget[1:0] != 2'b00);
            halted   <= (stateNext == HALT);
            if (redirAcc) begin
                fetchValid <= 1'b0;
            end else if (load) begin
                fetchValid <= 1'b1;
                fetchInst  <= bus.instruction;
                fetchPc    <= pc;
            end else if (fetchValid && bus.fetchReady) begin
                fetchValid <= 1'b0;
            end
        end
    end

    assign bus.instAddr   = pc;
    assign bus.fetchValid = fetchValid;
    assign bus.fetchInst  = fetchInst;
    assign bus.fetchPc    = fetchPc;
    assign bus.alignErr   = alignErr;
    assign bus.halted     = halted;
endmodule
